// File: rtl/use_stream_collector.sv
// Drains records from a ring of stream elements in strict token order and
// emits each one as AXI4-Stream beats, releasing the element after the last beat.
module use_stream_collector #(
  parameter int NUM_ELEMENTS          = 4,
  parameter int DATA_BUS_WIDTH_BYTES  = 8,
  parameter int MAX_RECORD_BYTES      = 64,
  parameter int RESET_TOKEN_HOLDER_ID = 0,
  localparam int LW = $clog2(MAX_RECORD_BYTES),
  localparam int EW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [NUM_ELEMENTS-1:0][MAX_RECORD_BYTES-1:0][7:0] useStreamIn,
  input  logic [NUM_ELEMENTS-1:0][LW-1:0]                   useStreamByteLengthIn,
  output logic [NUM_ELEMENTS-1:0]                           useStreamDataTaken,
  output logic [DATA_BUS_WIDTH_BYTES*8-1:0]                 m_axis_tdata,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]                   m_axis_tkeep,
  output logic                                              m_axis_tlast,
  output logic                                              m_axis_tvalid,
  input  logic                                              m_axis_tready,
  output logic [31:0]                                       recordsSent,
  output logic [1:0]                                        debugState,
  output logic [EW-1:0]                                     debugCurElem
);

  // Handshake: a beat transfers on any rising clk edge where m_axis_tvalid and
  // m_axis_tready are both high; once raised, tvalid and the beat hold until then.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [LW:0] BEAT_BYTES = (LW+1)'(DATA_BUS_WIDTH_BYTES);

  state_t        state, stateNext;
  logic [EW-1:0] curElem, curElemNext;
  logic [LW:0]   remaining, remainingNext;
  logic [LW:0]   offset, offsetNext;
  logic [31:0]   recordsSentNext;
  logic          lastBeat;

  assign lastBeat     = 32'(remaining) <= 32'(DATA_BUS_WIDTH_BYTES);
  assign debugState   = state;
  assign debugCurElem = curElem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      curElem     <= EW'(RESET_TOKEN_HOLDER_ID);
      remaining   <= '0;
      offset      <= '0;
      recordsSent <= '0;
    end else begin
      state       <= stateNext;
      curElem     <= curElemNext;
      remaining   <= remainingNext;
      offset      <= offsetNext;
      recordsSent <= recordsSentNext;
    end
  end

  always_comb begin
    stateNext       = state;
    curElemNext     = curElem;
    remainingNext   = remaining;
    offsetNext      = offset;
    recordsSentNext = recordsSent;
    case (state)
      IDLE: begin
        // Only the token holder is examined, so ring order is never broken.
        if (useStreamByteLengthIn[curElem] != '0) begin
          remainingNext = {1'b0, useStreamByteLengthIn[curElem]};
          offsetNext    = '0;
          stateNext     = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (lastBeat) begin
            stateNext = RELEASE;
          end else begin
            offsetNext    = offset + BEAT_BYTES;
            remainingNext = remaining - BEAT_BYTES;
          end
        end
      end
      RELEASE: begin
        recordsSentNext = recordsSent + 32'd1;
        curElemNext     = (32'(curElem) == NUM_ELEMENTS - 1) ? '0 : curElem + 1'b1;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Beat is a live mux of the element's buffer; the element holds it stable until released.
  always_comb begin
    logic [LW:0] byteIdx;
    byteIdx            = '0;
    m_axis_tvalid      = (state == SEND);
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tlast       = 1'b0;
    useStreamDataTaken = '0;
    if (state == SEND) begin
      m_axis_tlast = lastBeat;
      for (int k = 0; k < DATA_BUS_WIDTH_BYTES; k++) begin
        byteIdx = offset + (LW+1)'(k);
        if (32'(byteIdx) < 32'(MAX_RECORD_BYTES)) begin
          m_axis_tdata[8*k +: 8] = useStreamIn[curElem][byteIdx[LW-1:0]];
        end
        m_axis_tkeep[k] = (LW+1)'(k) < remaining;
      end
    end
    if (state == RELEASE) begin
      useStreamDataTaken[curElem] = 1'b1;
    end
  end

endmodule

// File: tb/tb_use_stream_collector.sv
// Directed bench for use_stream_collector: a bench-side element model feeds
// records, expected beats and release strobes are queued and matched in order.
module tb_use_stream_collector;

  localparam int NE  = 4;
  localparam int DBW = 8;
  localparam int MRB = 64;
  localparam int LW  = 6;
  localparam int BW  = DBW * 8 + DBW + 1;

  logic                            clk = 1'b0;
  logic                            reset;
  logic [NE-1:0][MRB-1:0][7:0]     streamData;
  logic [NE-1:0][LW-1:0]           lenIn;
  logic [NE-1:0]                   useStreamDataTaken;
  logic [DBW*8-1:0]                m_axis_tdata;
  logic [DBW-1:0]                  m_axis_tkeep;
  logic                            m_axis_tlast;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [31:0]                     recordsSent;
  logic [1:0]                      debugState;
  logic [1:0]                      debugCurElem;

  logic [BW-1:0] exp_q[$];
  int            strobe_q[$];
  int            total = 0;
  int            bad = 0;
  logic          prevStall = 1'b0;

  always #5 clk = ~clk;

  use_stream_collector #(
    .NUM_ELEMENTS(NE),
    .DATA_BUS_WIDTH_BYTES(DBW),
    .MAX_RECORD_BYTES(MRB),
    .RESET_TOKEN_HOLDER_ID(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .useStreamIn(streamData),
    .useStreamByteLengthIn(lenIn),
    .useStreamDataTaken(useStreamDataTaken),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .recordsSent(recordsSent),
    .debugState(debugState),
    .debugCurElem(debugCurElem)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected beats derived from the bench's own copy of the element buffer.
  task automatic expect_record(input int e, input int len);
    int off;
    int rem;
    logic [BW-1:0] beat;
    off = 0;
    rem = len;
    while (rem > 0) begin
      beat = '0;
      for (int k = 0; k < DBW; k++) begin
        if (off + k < MRB) beat[8*k +: 8] = streamData[e][off + k];
        if (k < rem) beat[DBW*8 + k] = 1'b1;
      end
      beat[BW-1] = (rem <= DBW);
      exp_q.push_back(beat);
      off += DBW;
      rem -= DBW;
    end
    strobe_q.push_back(e);
  endtask

  // Evaluate the current cycle (sampled #1 after the edge), then advance one clock.
  task automatic tick(input logic rdy);
    logic [BW-1:0] got;
    int e;
    m_axis_tready = rdy;
    if (prevStall) check("tvalid_hold", 128'(m_axis_tvalid), 128'(1));
    if (useStreamDataTaken != '0) begin
      if (strobe_q.size() == 0) begin
        check("strobe_unexpected", 128'(useStreamDataTaken), 128'(0));
      end else begin
        e = strobe_q.pop_front();
        check("strobe", 128'(useStreamDataTaken), 128'(1 << e));
        lenIn[e] = '0;
      end
    end
    if (m_axis_tvalid) begin
      got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 128'(m_axis_tvalid), 128'(0));
      end else begin
        check("beat", 128'(got), 128'(exp_q[0]));
        if (rdy) void'(exp_q.pop_front());
      end
    end
    prevStall = m_axis_tvalid && !rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int mode, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || strobe_q.size() != 0) && n < 300) begin
      tick((mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3)));
      n++;
    end
    check({tag, "_drained"}, 128'(exp_q.size() + strobe_q.size()), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    m_axis_tready = 1'b0;
    lenIn = '0;
    for (int e = 0; e < NE; e++)
      for (int b = 0; b < MRB; b++)
        streamData[e][b] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_tdata", 128'(m_axis_tdata), 128'(0));
    check("rst_taken", 128'(useStreamDataTaken), 128'(0));
    check("rst_records", 128'(recordsSent), 128'(0));
    check("rst_state", 128'(debugState), 128'(0));
    check("rst_cur", 128'(debugCurElem), 128'(0));
    reset = 1'b0;

    // 20-byte record on element 0: keeps FF, FF, 0F
    for (int b = 0; b < 20; b++) streamData[0][b] = 8'(b);
    lenIn[0] = 6'd20;
    expect_record(0, 20);
    drain(0, "len20");
    check("len20_records", 128'(recordsSent), 128'(1));
    check("len20_cur", 128'(debugCurElem), 128'(1));

    // Exact multiple then single byte, serviced in ring order 1, 2
    lenIn[1] = 6'd16;
    lenIn[2] = 6'd1;
    expect_record(1, 16);
    expect_record(2, 1);
    drain(0, "len16_len1");
    check("len16_len1_records", 128'(recordsSent), 128'(3));
    check("len16_len1_cur", 128'(debugCurElem), 128'(3));

    // Backpressure with tready pattern 1,0,0,1
    lenIn[3] = 6'd24;
    expect_record(3, 24);
    drain(1, "backpressure");
    check("bp_records", 128'(recordsSent), 128'(4));
    check("bp_cur_wrap", 128'(debugCurElem), 128'(0));

    // Element 1 ready first, but element 0 holds the token
    lenIn[1] = 6'd9;
    for (int i = 0; i < 10; i++) begin
      check("order_wait_tvalid", 128'(m_axis_tvalid), 128'(0));
      tick(1'b1);
    end
    lenIn[0] = 6'd5;
    expect_record(0, 5);
    expect_record(1, 9);
    drain(0, "order");
    check("order_records", 128'(recordsSent), 128'(6));
    check("order_cur", 128'(debugCurElem), 128'(2));

    lenIn[2] = 6'd17;
    lenIn[3] = 6'd3;
    expect_record(2, 17);
    expect_record(3, 3);
    drain(0, "len17_len3");
    check("len17_len3_records", 128'(recordsSent), 128'(8));
    check("len17_len3_cur", 128'(debugCurElem), 128'(0));

    // Reset after the first of three beats
    lenIn[0] = 6'd20;
    expect_record(0, 20);
    tick(1'b1);
    tick(1'b1);
    check("pre_reset_tvalid", 128'(m_axis_tvalid), 128'(1));
    exp_q.delete();
    strobe_q.delete();
    reset = 1'b1;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("midrst_taken", 128'(useStreamDataTaken), 128'(0));
    check("midrst_records", 128'(recordsSent), 128'(0));
    check("midrst_cur", 128'(debugCurElem), 128'(0));
    reset = 1'b0;
    prevStall = 1'b0;
    expect_record(0, 20);
    drain(0, "resend");
    check("resend_records", 128'(recordsSent), 128'(1));
    check("resend_cur", 128'(debugCurElem), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
